sel_sequencer: RTL



---
 rtl/sel_sequencer.sv | 116 +++++++++++
 1 files changed

// File: rtl/sel_sequencer.sv
// Timed select-code sweeper feeding the 1-to-2^n decoders: up/down sweep,
// programmable step interval, pass count, hold and abort; all outputs registered.
module sel_sequencer #(
  parameter int SEL_W  = 1,
  parameter int DIV_W  = 4,
  parameter int PASS_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              hold,
  input  logic              dir,
  input  logic [DIV_W-1:0]  div,
  input  logic [PASS_W-1:0] passes,
  output logic [SEL_W-1:0]  sel,
  output logic              sel_valid,
  output logic              wrap,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  localparam logic [SEL_W-1:0] SEL_MAX = '1;

  state_t              state;
  logic [DIV_W-1:0]    cnt;
  logic [PASS_W-1:0]   pass_cnt;
  logic                dir_q;
  logic [DIV_W-1:0]    div_q;
  logic [PASS_W-1:0]   passes_q;

  logic [SEL_W-1:0]    sel_first;
  logic [SEL_W-1:0]    sel_last;
  logic [PASS_W-1:0]   pass_next;
  logic                at_step;
  logic                at_term;
  logic                go_done;

  always_comb begin
    sel_first = dir_q ? SEL_MAX : '0;
    sel_last  = dir_q ? '0 : SEL_MAX;
    at_step   = (cnt == div_q);
    at_term   = (sel == sel_last);
    pass_next = (pass_cnt == '1) ? pass_cnt : pass_cnt + 1'b1;
    // Abort, or the terminal step of the final counted pass (never while held).
    go_done   = stop || (!hold && at_step && at_term &&
                         (passes_q != '0) && (pass_next == passes_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= '0;
      sel_valid <= 1'b0;
      wrap      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      pass_cnt  <= '0;
      dir_q     <= 1'b0;
      div_q     <= '0;
      passes_q  <= '0;
    end else begin
      wrap <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state     <= RUN;
            dir_q     <= dir;
            div_q     <= div;
            passes_q  <= passes;
            sel       <= dir ? SEL_MAX : '0;
            sel_valid <= 1'b1;
            busy      <= 1'b1;
            cnt       <= '0;
            pass_cnt  <= '0;
          end
        end
        RUN, HOLD: begin
          if (go_done) begin
            state     <= DONE;
            done      <= 1'b1;
            sel_valid <= 1'b0;
            sel       <= '0;
            busy      <= 1'b0;
            if (!stop) pass_cnt <= pass_next;
          end else if (hold) begin
            state <= HOLD;
          end else begin
            // Leaving HOLD takes the step on the same edge, so each sampled
            // hold=1 edge freezes exactly one cycle.
            state <= RUN;
            if (at_step) begin
              cnt <= '0;
              if (at_term) begin
                pass_cnt <= pass_next;
                sel      <= sel_first;
                wrap     <= 1'b1;
              end else begin
                sel <= dir_q ? sel - 1'b1 : sel + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
